// File: rtl/core_mem_arb_pkg.sv
// Shared types and bus widths for the core memory-port arbiter.
// Imported by the arbiter top, its response router and its checker.
package core_mem_arb_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } owner_t;
endpackage

// File: rtl/core_mem_arb_checker.sv
// Protocol checks for the arbiter: a held requester keeps its request up,
// and no grant is ever issued to an idle requester.
module core_mem_arb_checker (
  input logic g_clk,
  input logic g_resetn,
  input logic hold_i,
  input logic hold_d,
  input logic imem_req,
  input logic dmem_req,
  input logic imem_gnt,
  input logic dmem_gnt
);
  a_hold_i_req : assert property (@(posedge g_clk) disable iff (!g_resetn) hold_i |-> imem_req);
  a_hold_d_req : assert property (@(posedge g_clk) disable iff (!g_resetn) hold_d |-> dmem_req);
  a_imem_gnt   : assert property (@(posedge g_clk) disable iff (!g_resetn) imem_gnt |-> imem_req);
  a_dmem_gnt   : assert property (@(posedge g_clk) disable iff (!g_resetn) dmem_gnt |-> dmem_req);
endmodule

// File: rtl/core_mem_arb_rsp_route.sv
// Tracks which requester owns each outstanding read and steers the
// host response to that requester RSP_LATENCY cycles after its grant.
module core_mem_arb_rsp_route
  import core_mem_arb_pkg::*;
#(
  parameter int RSP_LATENCY = 1
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  fire,
  input  req_id_t               sel,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata
);
  owner_t [RSP_LATENCY-1:0] owner_r;
  owner_t                   last_s;

  // Owner shift register; reset discards every in-flight response
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      owner_r <= '0;
    end else begin
      owner_r[0] <= '{valid: fire, id: sel};
      for (int i = 1; i < RSP_LATENCY; i++) begin
        owner_r[i] <= owner_r[i-1];
      end
    end
  end

  assign last_s = owner_r[RSP_LATENCY-1];

  // Response demux; gated by reset so a response landing during reset is hidden
  always_comb begin
    imem_err   = 1'b0;
    imem_rdata = '0;
    dmem_err   = 1'b0;
    dmem_rdata = '0;
    if (g_resetn && last_s.valid) begin
      if (last_s.id == REQ_I) begin
        imem_err   = mem_err;
        imem_rdata = mem_rdata;
      end else begin
        dmem_err   = mem_err;
        dmem_rdata = mem_rdata;
      end
    end else begin
      imem_err = 1'b0;
      dmem_err = 1'b0;
    end
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one req/gnt memory port between fetch and load/store requesters,
// holding the selection across host stalls and routing responses back.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int RSP_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);
  localparam int             CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  req_id_t          sel_s;
  logic             req_sel_s;
  logic             fire_s;
  logic [CNT_W-1:0] starve_cnt_r;

  // Requester selection: held owner wins, otherwise dmem unless imem is starved
  always_comb begin
    sel_s = REQ_I;
    case (state_r)
      ARB_HOLD_I: sel_s = REQ_I;
      ARB_HOLD_D: sel_s = REQ_D;
      ARB_IDLE: begin
        if (imem_req && dmem_req) begin
          sel_s = (starve_cnt_r == CNT_MAX) ? REQ_I : REQ_D;
        end else if (dmem_req) begin
          sel_s = REQ_D;
        end else begin
          sel_s = REQ_I;
        end
      end
      default: sel_s = REQ_I;
    endcase
  end

  // Host-side request field mux
  always_comb begin
    if (sel_s == REQ_D) begin
      req_sel_s = dmem_req;
      mem_addr  = dmem_addr;
      mem_wen   = dmem_wen;
      mem_strb  = dmem_strb;
      mem_wdata = dmem_wdata;
    end else begin
      req_sel_s = imem_req;
      mem_addr  = imem_addr;
      mem_wen   = imem_wen;
      mem_strb  = imem_strb;
      mem_wdata = imem_wdata;
    end
  end

  assign mem_req  = req_sel_s && g_resetn;
  assign fire_s   = mem_req && mem_gnt;
  assign imem_gnt = fire_s && (sel_s == REQ_I);
  assign dmem_gnt = fire_s && (sel_s == REQ_D);

  // Next-state: lock onto a stalled requester until the host accepts it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (mem_req && !mem_gnt) begin
          state_nxt_s = (sel_s == REQ_D) ? ARB_HOLD_D : ARB_HOLD_I;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        if (mem_gnt || !mem_req) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Saturating count of cycles imem spends blocked behind dmem
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      starve_cnt_r <= '0;
    end else if (imem_gnt) begin
      starve_cnt_r <= '0;
    end else if (imem_req && (sel_s == REQ_D) && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  core_mem_arb_rsp_route #(
    .RSP_LATENCY(RSP_LATENCY)
  ) u_rsp_route (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .fire      (fire_s),
    .sel       (sel_s),
    .mem_err   (mem_err),
    .mem_rdata (mem_rdata),
    .imem_err  (imem_err),
    .imem_rdata(imem_rdata),
    .dmem_err  (dmem_err),
    .dmem_rdata(dmem_rdata)
  );

  core_mem_arb_checker u_chk (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .hold_i  (state_r == ARB_HOLD_I),
    .hold_d  (state_r == ARB_HOLD_D),
    .imem_req(imem_req),
    .dmem_req(dmem_req),
    .imem_gnt(imem_gnt),
    .dmem_gnt(dmem_gnt)
  );
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: one instance at latency 1 and one
// at latency 3 share the same stimulus and are compared to a behavioural model.
module tb_core_mem_arbiter;
  import core_mem_arb_pkg::*;
  localparam int SMAX = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, dmem_req, dmem_wen, mem_gnt, mem_err;
  logic [31:0] imem_addr, dmem_addr;
  logic [7:0]  imem_strb, dmem_strb;
  logic [63:0] imem_wdata, dmem_wdata, mem_rdata;
  // latency-1 instance outputs
  logic        imem_gnt, imem_err, dmem_gnt, dmem_err, mem_req, mem_wen;
  logic [63:0] imem_rdata, dmem_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_strb;
  // latency-3 instance outputs
  logic        imem_gnt_3, imem_err_3, dmem_gnt_3, dmem_err_3, mem_req_3, mem_wen_3;
  logic [63:0] imem_rdata_3, dmem_rdata_3, mem_wdata_3;
  logic [31:0] mem_addr_3;
  logic [7:0]  mem_strb_3;

  int checks = 0;
  int failures = 0;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter #(.RSP_LATENCY(1), .STARVE_MAX(SMAX)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  core_mem_arbiter #(.RSP_LATENCY(3), .STARVE_MAX(SMAX)) dut3 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_gnt(imem_gnt_3), .imem_err(imem_err_3), .imem_rdata(imem_rdata_3),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt_3), .dmem_err(dmem_err_3), .dmem_rdata(dmem_rdata_3),
    .mem_req(mem_req_3), .mem_addr(mem_addr_3), .mem_wen(mem_wen_3), .mem_strb(mem_strb_3),
    .mem_wdata(mem_wdata_3), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  // Behavioural model: who holds the port, how long imem has waited, and
  // which requester (0=I, 1=D, -1=none) was granted in each recent cycle.
  int          m_hold;
  int          m_starve;
  int          cyc;
  int          hist[8];
  logic        e_sel, e_mreq, e_ig, e_dg, e_wen;
  logic [31:0] e_addr;
  logic [7:0]  e_strb;
  logic [63:0] e_wdata, e_ird1, e_drd1, e_ird3, e_drd3;
  logic        e_ierr1, e_derr1, e_ierr3, e_derr3;

  task automatic model_eval();
    int own1, own3;
    if (m_hold == 1) e_sel = 1'b0;
    else if (m_hold == 2) e_sel = 1'b1;
    else if (imem_req && dmem_req) e_sel = (m_starve >= SMAX) ? 1'b0 : 1'b1;
    else e_sel = dmem_req;
    e_mreq  = g_resetn && (e_sel ? dmem_req : imem_req);
    e_ig    = e_mreq && mem_gnt && !e_sel;
    e_dg    = e_mreq && mem_gnt && e_sel;
    e_addr  = e_sel ? dmem_addr : imem_addr;
    e_wen   = e_sel ? dmem_wen : imem_wen;
    e_strb  = e_sel ? dmem_strb : imem_strb;
    e_wdata = e_sel ? dmem_wdata : imem_wdata;
    own1 = g_resetn ? hist[3'(cyc - 1)] : -1;
    own3 = g_resetn ? hist[3'(cyc - 3)] : -1;
    e_ird1 = (own1 == 0) ? mem_rdata : 64'h0;  e_ierr1 = (own1 == 0) && mem_err;
    e_drd1 = (own1 == 1) ? mem_rdata : 64'h0;  e_derr1 = (own1 == 1) && mem_err;
    e_ird3 = (own3 == 0) ? mem_rdata : 64'h0;  e_ierr3 = (own3 == 0) && mem_err;
    e_drd3 = (own3 == 1) ? mem_rdata : 64'h0;  e_derr3 = (own3 == 1) && mem_err;
  endtask

  task automatic model_advance();
    hist[3'(cyc)] = (e_mreq && mem_gnt) ? int'(e_sel) : -1;
    if (!g_resetn) begin
      m_hold = 0;
      m_starve = 0;
      foreach (hist[i]) hist[i] = -1;
    end else begin
      if (m_hold == 0) begin
        if (e_mreq && !mem_gnt) m_hold = int'(e_sel) + 1;
      end else if (mem_gnt || !e_mreq) begin
        m_hold = 0;
      end
      if (e_ig) m_starve = 0;
      else if (imem_req && e_sel && m_starve < SMAX) m_starve++;
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge g_clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge g_clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0; mem_gnt = 1'b1; mem_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) g_resetn = 1'b1;
      mem_rdata = {$urandom, $urandom};
      settle();
      checks++;
      if ({imem_gnt, dmem_gnt, imem_err, dmem_err, mem_req, imem_gnt_3, dmem_gnt_3, mem_req_3} !== 8'h0) begin
        failures++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=0", i, {imem_gnt, dmem_gnt, imem_err, dmem_err, mem_req});
      end
      checks++;
      if ((imem_rdata | dmem_rdata | imem_rdata_3 | dmem_rdata_3) !== 64'h0 || imem_err_3 || dmem_err_3) begin
        failures++;
        $display("FAIL reset_data cyc=%0d got i=%h d=%h exp=0", i, imem_rdata, dmem_rdata);
      end
      advance();
    end
  endtask

  task automatic test_imem_only();
    imem_req = 1'b1; imem_addr = 32'h1000_0000; dmem_req = 1'b0; mem_gnt = 1'b1; mem_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = {$urandom, $urandom};
      settle();
      checks++;
      if (imem_gnt !== (i < 2) || dmem_gnt !== 1'b0) begin
        failures++;
        $display("FAIL imem_only_gnt cyc=%0d got=%b%b exp=%b0", i, imem_gnt, dmem_gnt, (i < 2));
      end
      if (i < 2) begin
        checks++;
        if (mem_addr !== ((i == 0) ? 32'h1000_0000 : 32'h1000_0008)) begin
          failures++;
          $display("FAIL imem_only_addr cyc=%0d got=%h", i, mem_addr);
        end
      end
      if (i > 0) begin
        checks++;
        if (imem_rdata !== mem_rdata || dmem_rdata !== 64'h0) begin
          failures++;
          $display("FAIL imem_only_rdata cyc=%0d got i=%h d=%h exp i=%h d=0", i, imem_rdata, dmem_rdata, mem_rdata);
        end
      end
      advance();
      if (i == 0) imem_addr = 32'h1000_0008;
      else imem_req = 1'b0;
    end
  endtask

  task automatic test_starvation();
    int first_d, first_i, second_i;
    first_d = -1; first_i = -1; second_i = -1;
    imem_req = 1'b1; dmem_req = 1'b1; mem_gnt = 1'b1;
    imem_addr = 32'h1000_0040; dmem_addr = 32'h2000_0000;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++;
      if ({imem_gnt, dmem_gnt} !== {e_ig, e_dg}) begin
        failures++;
        $display("FAIL starve_gnt cyc=%0d got=%b%b exp=%b%b", i, imem_gnt, dmem_gnt, e_ig, e_dg);
      end
      if (dmem_gnt && first_d < 0) first_d = i;
      if (imem_gnt && first_i >= 0 && second_i < 0) second_i = i;
      if (imem_gnt && first_i < 0) first_i = i;
      advance();
      if (e_ig) imem_addr = imem_addr + 32'd8;
      if (e_dg) dmem_addr = dmem_addr + 32'd8;
    end
    checks++;
    if (first_d != 0 || first_i != 4 || second_i != 9) begin
      failures++;
      $display("FAIL starve_order got d=%0d i=%0d i2=%0d exp d=0 i=4 i2=9", first_d, first_i, second_i);
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    settle();
    advance();
  endtask

  task automatic test_hold();
    dmem_req = 1'b1; dmem_addr = 32'h2000_0040; imem_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin imem_req = 1'b1; imem_addr = 32'h1000_0100; end
      mem_gnt = (i >= 3);
      settle();
      if (i <= 3) begin
        checks++;
        if (mem_addr !== 32'h2000_0040 || mem_req !== 1'b1) begin
          failures++;
          $display("FAIL hold_addr cyc=%0d got=%h req=%b exp=20000040 req=1", i, mem_addr, mem_req);
        end
      end
      checks++;
      if (dmem_gnt !== (i == 3) || imem_gnt !== (i == 4)) begin
        failures++;
        $display("FAIL hold_gnt cyc=%0d got i=%b d=%b exp i=%b d=%b", i, imem_gnt, dmem_gnt, (i == 4), (i == 3));
      end
      advance();
      if (i == 3) dmem_req = 1'b0;
      if (i == 4) imem_req = 1'b0;
    end
  endtask

  task automatic test_alt_err();
    mem_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_req = (i % 2 == 0); dmem_req = (i % 2 == 1);
      imem_addr = 32'h1000_0000 + 32'(i * 8); dmem_addr = 32'h2000_0000 + 32'(i * 8);
      mem_err = (i > 0) && (i % 2 == 0);
      mem_rdata = {$urandom, $urandom};
      settle();
      checks++;
      if ({imem_gnt, dmem_gnt} !== {imem_req, dmem_req}) begin
        failures++;
        $display("FAIL alt_gnt cyc=%0d got=%b%b exp=%b%b", i, imem_gnt, dmem_gnt, imem_req, dmem_req);
      end
      if (i > 0 && i % 2 == 0) begin
        checks++;
        if (dmem_rdata !== mem_rdata || dmem_err !== 1'b1 || imem_rdata !== 64'h0 || imem_err !== 1'b0) begin
          failures++;
          $display("FAIL alt_d_rsp cyc=%0d got d=%h/%b i=%h/%b exp d=%h/1", i, dmem_rdata, dmem_err, imem_rdata, imem_err, mem_rdata);
        end
      end else if (i > 0) begin
        checks++;
        if (imem_rdata !== mem_rdata || imem_err !== 1'b0 || dmem_rdata !== 64'h0 || dmem_err !== 1'b0) begin
          failures++;
          $display("FAIL alt_i_rsp cyc=%0d got i=%h/%b d=%h/%b exp i=%h/0", i, imem_rdata, imem_err, dmem_rdata, dmem_err, mem_rdata);
        end
      end
      advance();
    end
    imem_req = 1'b0; dmem_req = 1'b0; mem_err = 1'b0;
    settle();
    advance();
  endtask

  task automatic test_reset_mid();
    imem_req = 1'b1; imem_addr = 32'h1000_0200; mem_gnt = 1'b1; mem_err = 1'b0;
    settle();
    checks++;
    if (imem_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_gnt got=%b exp=1", imem_gnt);
    end
    advance();
    imem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g_resetn = (i != 0);
      mem_rdata = {$urandom, $urandom}; mem_err = 1'b1;
      settle();
      checks++;
      if ({imem_gnt, dmem_gnt, imem_err, dmem_err, mem_req, imem_err_3, dmem_err_3} !== 7'h0 ||
          (imem_rdata | dmem_rdata | imem_rdata_3 | dmem_rdata_3) !== 64'h0) begin
        failures++;
        $display("FAIL rstmid_out cyc=%0d got ctl=%b i=%h d=%h exp 0", i,
                 {imem_gnt, dmem_gnt, imem_err, dmem_err, mem_req}, imem_rdata, dmem_rdata);
      end
      advance();
    end
    mem_err = 1'b0;
  endtask

  task automatic test_latency3();
    int own3[6] = '{-1, -1, -1, 0, 1, 0};
    mem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_req = (i == 0) || (i == 2); dmem_req = (i == 1);
      imem_addr = 32'h1000_0300 + 32'(i * 8); dmem_addr = 32'h2000_0300;
      mem_rdata = {$urandom, $urandom}; mem_err = (i == 4);
      settle();
      checks++;
      if (imem_rdata_3 !== ((own3[i] == 0) ? mem_rdata : 64'h0) ||
          dmem_rdata_3 !== ((own3[i] == 1) ? mem_rdata : 64'h0) ||
          dmem_err_3 !== (own3[i] == 1) || imem_err_3 !== 1'b0) begin
        failures++;
        $display("FAIL lat3_rsp cyc=%0d got i=%h d=%h derr=%b owner=%0d mem=%h", i,
                 imem_rdata_3, dmem_rdata_3, dmem_err_3, own3[i], mem_rdata);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic last_ig, last_dg;
    for (int i = 0; i < 400; i++) begin
      g_resetn = ($urandom_range(0, 49) != 0);
      mem_gnt = ($urandom_range(0, 9) < 7);
      mem_err = $urandom_range(0, 1);
      mem_rdata = {$urandom, $urandom};
      settle();
      checks++;
      if ({imem_gnt, dmem_gnt, mem_req, imem_gnt_3, dmem_gnt_3, mem_req_3} !== {e_ig, e_dg, e_mreq, e_ig, e_dg, e_mreq}) begin
        failures++;
        $display("FAIL rnd_gnt cyc=%0d got=%b%b%b/%b%b%b exp=%b%b%b", i, imem_gnt, dmem_gnt, mem_req,
                 imem_gnt_3, dmem_gnt_3, mem_req_3, e_ig, e_dg, e_mreq);
      end
      if (e_mreq) begin
        checks++;
        if ({mem_addr, mem_wen, mem_strb, mem_wdata} !== {e_addr, e_wen, e_strb, e_wdata} ||
            {mem_addr_3, mem_wen_3, mem_strb_3, mem_wdata_3} !== {e_addr, e_wen, e_strb, e_wdata}) begin
          failures++;
          $display("FAIL rnd_mux cyc=%0d got a=%h w=%b s=%h exp a=%h w=%b s=%h", i, mem_addr, mem_wen, mem_strb, e_addr, e_wen, e_strb);
        end
      end
      checks++;
      if ({imem_err, imem_rdata, dmem_err, dmem_rdata} !== {e_ierr1, e_ird1, e_derr1, e_drd1}) begin
        failures++;
        $display("FAIL rnd_rsp1 cyc=%0d got i=%h/%b d=%h/%b exp i=%h/%b d=%h/%b", i, imem_rdata, imem_err,
                 dmem_rdata, dmem_err, e_ird1, e_ierr1, e_drd1, e_derr1);
      end
      checks++;
      if ({imem_err_3, imem_rdata_3, dmem_err_3, dmem_rdata_3} !== {e_ierr3, e_ird3, e_derr3, e_drd3}) begin
        failures++;
        $display("FAIL rnd_rsp3 cyc=%0d got i=%h/%b d=%h/%b exp i=%h/%b d=%h/%b", i, imem_rdata_3, imem_err_3,
                 dmem_rdata_3, dmem_err_3, e_ird3, e_ierr3, e_drd3, e_derr3);
      end
      last_ig = e_ig; last_dg = e_dg;
      advance();
      if (last_ig || !imem_req) begin
        imem_req = $urandom_range(0, 1); imem_addr = $urandom & 32'hFFFF_FFF8;
        imem_wen = 1'b0; imem_strb = 8'(($urandom)); imem_wdata = {$urandom, $urandom};
      end
      if (last_dg || !dmem_req) begin
        dmem_req = $urandom_range(0, 1); dmem_addr = $urandom & 32'hFFFF_FFF8;
        dmem_wen = $urandom_range(0, 1); dmem_strb = 8'(($urandom)); dmem_wdata = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    g_resetn = 1'b0;
    imem_req = 1'b0; imem_addr = 32'h0; imem_wen = 1'b0; imem_strb = 8'h0; imem_wdata = 64'h0;
    dmem_req = 1'b0; dmem_addr = 32'h0; dmem_wen = 1'b0; dmem_strb = 8'hFF; dmem_wdata = 64'h0;
    mem_gnt = 1'b0; mem_err = 1'b0; mem_rdata = 64'h0;
    m_hold = 0; m_starve = 0; cyc = 0;
    foreach (hist[i]) hist[i] = -1;
    #1;
    test_reset();
    test_imem_only();
    test_starvation();
    test_hold();
    test_alt_err();
    test_reset_mid();
    test_latency3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
